// File: rtl/mem_pkg.sv
// Shared types and constants for the MIPS memory stage: FSM states,
// write-back select encodings and the MEM/WB register layout.
package mem_pkg;

    localparam int TIMEOUT_DEF = 16;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC  = 2'b10;

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    typedef struct packed {
        logic        reg_write;
        logic [1:0]  mem_to_reg;
        logic [4:0]  reg_dst;
        logic [31:0] mem_data;
        logic [31:0] alu_result;
        logic [31:0] pc_plus4;
    } mem_wb_t;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register. A bubble clears it the same way reset does,
// so a stalled instruction can never be written back twice.
module mem_wb_reg
    import mem_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    bubble,
    input  mem_wb_t d,
    output mem_wb_t q
);

    // NOTE: <= so every register samples pre-edge values regardless of block order.
    always_ff @(posedge clk) begin
        if (rst || bubble) begin
            q <= '{reg_write: 1'b0, mem_to_reg: WB_ALU, default: '0};
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MIPS memory stage: drives a variable-latency data-memory handshake,
// stalls the front of the pipe while an access is pending, owns MEM/WB.
module mem_stage_ctrl
    import mem_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteEXMEM,
    input  logic        MemReadEXMEM,
    input  logic        MemWriteEXMEM,
    input  logic [1:0]  MemToRegEXMEM,
    input  logic [4:0]  muxRegDstEXMEM,
    input  logic [31:0] adderPcOutEXMEM,
    input  logic [31:0] aluResultEXMEM,
    input  logic [31:0] muxBEXMEM,
    output logic        memReq,
    output logic        memWe,
    output logic [31:0] memAddr,
    output logic [31:0] memWdata,
    input  logic [31:0] memRdata,
    input  logic        memAck,
    output logic        stall,
    output logic        alignErr,
    output logic        memErr,
    output logic        RegWriteMEMWB,
    output logic [1:0]  MemToRegMEMWB,
    output logic [4:0]  muxRegDstMEMWB,
    output logic [31:0] memDataMEMWB,
    output logic [31:0] aluResultMEMWB,
    output logic [31:0] adderPcOutMEMWB
);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             access;
    logic             misaligned;
    logic             align_drop;
    logic             timeout_hit;
    logic             req_int;
    logic             stall_int;
    mem_wb_t          wb_d;
    mem_wb_t          wb_q;

    assign access      = MemReadEXMEM | MemWriteEXMEM;
    assign misaligned  = access & (aluResultEXMEM[1:0] != 2'b00);
    assign align_drop  = (state == IDLE) & misaligned;
    assign timeout_hit = (state == WAIT) & ~memAck & (cnt == CNT_W'(TIMEOUT - 1));

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        state_nxt = state;
        req_int   = 1'b0;
        stall_int = 1'b0;
        case (state)
            IDLE: begin
                if (access && !misaligned) begin
                    req_int   = 1'b1;
                    stall_int = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                req_int = 1'b1;
                if (memAck || timeout_hit) begin
                    state_nxt = IDLE;
                end else begin
                    stall_int = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            memErr <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= (state == IDLE) ? '0 : cnt + 1'b1;
            if (timeout_hit) begin
                memErr <= 1'b1;
            end
        end
    end

    // Reset abandons any pending access immediately, even mid-WAIT.
    assign memReq   = req_int & ~rst;
    assign stall    = stall_int & ~rst;
    assign alignErr = align_drop & ~rst;

    assign memWe    = MemWriteEXMEM;
    assign memAddr  = aluResultEXMEM;
    assign memWdata = muxBEXMEM;

    // Dropped accesses (misaligned or timed out) still retire, but never write a register.
    always_comb begin
        wb_d.reg_write  = RegWriteEXMEM & ~align_drop & ~timeout_hit;
        wb_d.mem_to_reg = MemToRegEXMEM;
        wb_d.reg_dst    = muxRegDstEXMEM;
        wb_d.mem_data   = ((state == WAIT) && memAck && MemReadEXMEM && !MemWriteEXMEM)
                          ? memRdata : '0;
        wb_d.alu_result = aluResultEXMEM;
        wb_d.pc_plus4   = adderPcOutEXMEM;
    end

    mem_wb_reg u_mem_wb_reg (
        .clk    (clk),
        .rst    (rst),
        .bubble (stall_int),
        .d      (wb_d),
        .q      (wb_q)
    );

    assign RegWriteMEMWB   = wb_q.reg_write;
    assign MemToRegMEMWB   = wb_q.mem_to_reg;
    assign muxRegDstMEMWB  = wb_q.reg_dst;
    assign memDataMEMWB    = wb_q.mem_data;
    assign aluResultMEMWB  = wb_q.alu_result;
    assign adderPcOutMEMWB = wb_q.pc_plus4;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: directed instructions push expected
// MEM/WB contents; a monitor compares them whenever MEM/WB retires an instruction.
module tb_mem_stage_ctrl;
    import mem_pkg::*;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        RegWriteEXMEM = 1'b0;
    logic        MemReadEXMEM = 1'b0;
    logic        MemWriteEXMEM = 1'b0;
    logic [1:0]  MemToRegEXMEM = 2'b00;
    logic [4:0]  muxRegDstEXMEM = 5'd0;
    logic [31:0] adderPcOutEXMEM = 32'h0;
    logic [31:0] aluResultEXMEM = 32'h0;
    logic [31:0] muxBEXMEM = 32'h0;
    logic [31:0] memRdata = 32'h0;
    logic        memAck = 1'b0;
    logic        memReq;
    logic        memWe;
    logic [31:0] memAddr;
    logic [31:0] memWdata;
    logic        stall;
    logic        alignErr;
    logic        memErr;
    logic        RegWriteMEMWB;
    logic [1:0]  MemToRegMEMWB;
    logic [4:0]  muxRegDstMEMWB;
    logic [31:0] memDataMEMWB;
    logic [31:0] aluResultMEMWB;
    logic [31:0] adderPcOutMEMWB;

    int n_vec = 0;
    int n_err = 0;
    mem_wb_t sb[$];

    always #5 clk = ~clk;

    mem_stage_ctrl #(.TIMEOUT(TO), .CNT_W(3)) dut (
        .clk             (clk),
        .rst             (rst),
        .RegWriteEXMEM   (RegWriteEXMEM),
        .MemReadEXMEM    (MemReadEXMEM),
        .MemWriteEXMEM   (MemWriteEXMEM),
        .MemToRegEXMEM   (MemToRegEXMEM),
        .muxRegDstEXMEM  (muxRegDstEXMEM),
        .adderPcOutEXMEM (adderPcOutEXMEM),
        .aluResultEXMEM  (aluResultEXMEM),
        .muxBEXMEM       (muxBEXMEM),
        .memReq          (memReq),
        .memWe           (memWe),
        .memAddr         (memAddr),
        .memWdata        (memWdata),
        .memRdata        (memRdata),
        .memAck          (memAck),
        .stall           (stall),
        .alignErr        (alignErr),
        .memErr          (memErr),
        .RegWriteMEMWB   (RegWriteMEMWB),
        .MemToRegMEMWB   (MemToRegMEMWB),
        .muxRegDstMEMWB  (muxRegDstMEMWB),
        .memDataMEMWB    (memDataMEMWB),
        .aluResultMEMWB  (aluResultMEMWB),
        .adderPcOutMEMWB (adderPcOutMEMWB)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_exmem(input logic rw, input logic mr, input logic mw,
                               input logic [1:0] m2r, input logic [4:0] dst,
                               input logic [31:0] pc, input logic [31:0] alu,
                               input logic [31:0] wd);
        RegWriteEXMEM   = rw;
        MemReadEXMEM    = mr;
        MemWriteEXMEM   = mw;
        MemToRegEXMEM   = m2r;
        muxRegDstEXMEM  = dst;
        adderPcOutEXMEM = pc;
        aluResultEXMEM  = alu;
        muxBEXMEM       = wd;
    endtask

    // Called just after a posedge; holds one instruction in EX/MEM until it retires.
    // ack_at: WAIT cycle (1-based) carrying memAck, 0 = never ack.
    task automatic apply(input logic rw, input logic mr, input logic mw,
                         input logic [1:0] m2r, input logic [4:0] dst,
                         input logic [31:0] pc, input logic [31:0] alu,
                         input logic [31:0] wd, input int ack_at,
                         input logic [31:0] rdata, input logic exp_err,
                         input mem_wb_t exp);
        logic acc;
        logic mis;
        logic exp_stall;
        logic done;
        acc  = mr | mw;
        mis  = acc && (alu[1:0] != 2'b00);
        done = 1'b0;
        drive_exmem(rw, mr, mw, m2r, dst, pc, alu, wd);
        for (int k = 0; k <= TO + 1; k++) begin
            memAck   = acc && !mis && (ack_at != 0) && (k == ack_at);
            memRdata = memAck ? rdata : 32'h0;
            #2;
            if (k == 0) begin
                exp_stall = acc && !mis;
                check("memReq_idle", 32'(memReq), 32'(acc && !mis));
                check("alignErr", 32'(alignErr), 32'(mis));
                check("memErr", 32'(memErr), 32'(exp_err));
            end else begin
                exp_stall = !(k == ack_at) && !(ack_at == 0 && k == TO);
                check("memReq_wait", 32'(memReq), 32'd1);
            end
            check("stall", 32'(stall), 32'(exp_stall));
            if (acc && !mis) begin
                check("memWe", 32'(memWe), 32'(mw));
                check("memAddr", memAddr, alu);
                check("memWdata", memWdata, wd);
            end
            if (!exp_stall) begin
                sb.push_back(exp);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            if (done) break;
        end
        memAck   = 1'b0;
        memRdata = 32'h0;
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL retire_bound: instruction at pc 0x%08h never released stall", pc);
        end
    endtask

    // Monitor: an edge with stall and rst low retires one instruction into MEM/WB.
    initial begin
        logic    prev_bubble;
        bit      armed;
        mem_wb_t e;
        armed       = 1'b0;
        prev_bubble = 1'b1;
        forever begin
            @(negedge clk);
            if (armed) begin
                if (prev_bubble) begin
                    check("bubble_reg_write", 32'(RegWriteMEMWB), 32'd0);
                    check("bubble_mem_to_reg", 32'(MemToRegMEMWB), 32'(WB_ALU));
                    check("bubble_data", memDataMEMWB | aluResultMEMWB | adderPcOutMEMWB
                          | 32'(muxRegDstMEMWB), 32'h0);
                end else if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_retire: MEM/WB loaded with no instruction pending (pc 0x%08h)",
                             adderPcOutMEMWB);
                end else begin
                    e = sb.pop_front();
                    check("wb_reg_write", 32'(RegWriteMEMWB), 32'(e.reg_write));
                    check("wb_mem_to_reg", 32'(MemToRegMEMWB), 32'(e.mem_to_reg));
                    check("wb_reg_dst", 32'(muxRegDstMEMWB), 32'(e.reg_dst));
                    check("wb_mem_data", memDataMEMWB, e.mem_data);
                    check("wb_alu_result", aluResultMEMWB, e.alu_result);
                    check("wb_pc_plus4", adderPcOutMEMWB, e.pc_plus4);
                end
            end
            prev_bubble = rst || stall;
            armed       = 1'b1;
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset_memErr", 32'(memErr), 32'd0);
        check("reset_memReq", 32'(memReq), 32'd0);
        check("reset_stall", 32'(stall), 32'd0);
        rst = 1'b0;

        // add r5: plain ALU op, 1-cycle latency
        apply(1, 0, 0, WB_ALU, 5'd5, 32'h4, 32'h10, 32'h0, 0, 32'h0, 0,
              '{reg_write: 1'b1, mem_to_reg: WB_ALU, reg_dst: 5'd5, mem_data: 32'h0,
                alu_result: 32'h10, pc_plus4: 32'h4});
        // lw r8, ack on third WAIT cycle
        apply(1, 1, 0, WB_MEM, 5'd8, 32'h8, 32'h100, 32'h0, 3, 32'hDEADBEEF, 0,
              '{reg_write: 1'b1, mem_to_reg: WB_MEM, reg_dst: 5'd8, mem_data: 32'hDEADBEEF,
                alu_result: 32'h100, pc_plus4: 32'h8});
        // sw, minimum 2-cycle occupancy; rdata on the bus must not leak into MEM/WB
        apply(0, 0, 1, WB_ALU, 5'd0, 32'hC, 32'h8, 32'h55, 1, 32'h12345678, 0,
              '{reg_write: 1'b0, mem_to_reg: WB_ALU, reg_dst: 5'd0, mem_data: 32'h0,
                alu_result: 32'h8, pc_plus4: 32'hC});
        // misaligned lw: dropped, no request
        apply(1, 1, 0, WB_MEM, 5'd9, 32'h10, 32'h102, 32'h0, 0, 32'h0, 0,
              '{reg_write: 1'b0, mem_to_reg: WB_MEM, reg_dst: 5'd9, mem_data: 32'h0,
                alu_result: 32'h102, pc_plus4: 32'h10});
        // read+write both set: treated as a write
        apply(1, 1, 1, WB_MEM, 5'd3, 32'h14, 32'h20, 32'hAA, 2, 32'hCAFEF00D, 0,
              '{reg_write: 1'b1, mem_to_reg: WB_MEM, reg_dst: 5'd3, mem_data: 32'h0,
                alu_result: 32'h20, pc_plus4: 32'h14});
        // jal-style pc+4 write-back
        apply(1, 0, 0, WB_PC, 5'd31, 32'h18, 32'h7, 32'h0, 0, 32'h0, 0,
              '{reg_write: 1'b1, mem_to_reg: WB_PC, reg_dst: 5'd31, mem_data: 32'h0,
                alu_result: 32'h7, pc_plus4: 32'h18});
        // lw that never gets acked: timeout after TO WAIT cycles
        apply(1, 1, 0, WB_MEM, 5'd4, 32'h1C, 32'h40, 32'h0, 0, 32'h0, 0,
              '{reg_write: 1'b0, mem_to_reg: WB_MEM, reg_dst: 5'd4, mem_data: 32'h0,
                alu_result: 32'h40, pc_plus4: 32'h1C});
        // memErr now sticky
        apply(1, 0, 0, WB_ALU, 5'd6, 32'h20, 32'h99, 32'h0, 0, 32'h0, 1,
              '{reg_write: 1'b1, mem_to_reg: WB_ALU, reg_dst: 5'd6, mem_data: 32'h0,
                alu_result: 32'h99, pc_plus4: 32'h20});
        // back-to-back load straight after an ALU op, ack on first WAIT cycle
        apply(1, 1, 0, WB_MEM, 5'd12, 32'h24, 32'h44, 32'h0, 1, 32'h0BADF00D, 1,
              '{reg_write: 1'b1, mem_to_reg: WB_MEM, reg_dst: 5'd12, mem_data: 32'h0BADF00D,
                alu_result: 32'h44, pc_plus4: 32'h24});

        // reset in the middle of WAIT
        drive_exmem(1, 1, 0, WB_MEM, 5'd7, 32'h28, 32'h200, 32'h0);
        #2;
        check("rstwait_req0", 32'(memReq), 32'd1);
        check("rstwait_stall0", 32'(stall), 32'd1);
        @(posedge clk);
        #3;
        check("rstwait_req1", 32'(memReq), 32'd1);
        check("rstwait_stall1", 32'(stall), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #2;
        check("rstwait_req_gated", 32'(memReq), 32'd0);
        check("rstwait_stall_gated", 32'(stall), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive_exmem(1, 0, 0, WB_ALU, 5'd10, 32'h2C, 32'h33, 32'h0);
        memAck   = 1'b1;
        memRdata = 32'h00000BAD;
        #2;
        check("post_rst_memErr", 32'(memErr), 32'd0);
        check("stray_ack_req", 32'(memReq), 32'd0);
        check("stray_ack_stall", 32'(stall), 32'd0);
        sb.push_back('{reg_write: 1'b1, mem_to_reg: WB_ALU, reg_dst: 5'd10, mem_data: 32'h0,
                       alu_result: 32'h33, pc_plus4: 32'h2C});
        @(posedge clk);
        #1;
        memAck   = 1'b0;
        memRdata = 32'h0;
        rst      = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
